// File: rtl/pkt_load_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// pkt_load_unit_if: request, packet-buffer and response bundle. Rev 1.0
// ------------------------------------------------------------------------
interface pkt_load_unit_if #(
  parameter int ADDR_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_be;
  logic [ADDR_W-1:0] pkt_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_be, pkt_len, mem_rdata, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_be, pkt_len, mem_rdata, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/pkt_load_unit.sv
`default_nettype none
// ------------------------------------------------------------------------
// pkt_load_unit: byte-serial packet load with network-to-host swap. Rev 1.0
// ------------------------------------------------------------------------
module pkt_load_unit #(
  parameter int ADDR_W = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  pkt_load_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        nm1_q, nm1_d;
  logic              be_q, be_d;
  logic [2:0]        idx_q, idx_d;
  logic              pend_q, pend_d;
  logic [2:0]        pend_idx_q, pend_idx_d;
  logic [63:0]       asm_q, asm_d;
  logic              err_q, err_d;

  logic [2:0]        w_req_nm1;
  logic [3:0]        w_req_n;
  logic [ADDR_W:0]   w_end;
  logic              w_oob;
  logic [2:0]        w_lane;

  always_comb begin
    w_req_nm1 = 3'd0;
    case (bus.req_size)
      2'b00:   w_req_nm1 = 3'd0;
      2'b01:   w_req_nm1 = 3'd1;
      2'b10:   w_req_nm1 = 3'd3;
      default: w_req_nm1 = 3'd7;
    endcase
  end

  // One extra bit so that an address wrap shows up as an overrun.
  assign w_req_n = {1'b0, w_req_nm1} + 4'd1;
  assign w_end   = {1'b0, bus.req_addr} + {{(ADDR_W-3){1'b0}}, w_req_n};
  assign w_oob   = (w_end > {1'b0, bus.pkt_len});
  assign w_lane  = be_q ? (nm1_q - pend_idx_q) : pend_idx_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nm1_d      = nm1_q;
    be_d       = be_q;
    idx_d      = idx_q;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    asm_d      = asm_q;
    err_d      = err_q;

    // A read issued last cycle returns its byte now.
    if (pend_q) begin
      asm_d[{w_lane, 3'b000} +: 8] = bus.mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          asm_d = 64'd0;
          if (w_oob) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            base_d  = bus.req_addr;
            nm1_d   = w_req_nm1;
            be_d    = bus.req_be;
            idx_d   = 3'd0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        pend_d     = 1'b1;
        pend_idx_d = idx_q;
        idx_d      = idx_q + 3'd1;
        if (idx_q == nm1_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_RESP;
      end
      default: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      nm1_q      <= 3'd0;
      be_q       <= 1'b0;
      idx_q      <= 3'd0;
      pend_q     <= 1'b0;
      pend_idx_q <= 3'd0;
      asm_q      <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nm1_q      <= nm1_d;
      be_q       <= be_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      asm_q      <= asm_d;
      err_q      <= err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.mem_rd_en = (state_q == S_ISSUE);
  assign bus.mem_addr  = (state_q == S_ISSUE) ? (base_q + {{(ADDR_W-3){1'b0}}, idx_q}) : '0;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_data  = asm_q;
  assign bus.rsp_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_load_unit.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_pkt_load_unit: scoreboard bench for the packet load unit. Rev 1.0
// ------------------------------------------------------------------------
module tb_pkt_load_unit;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pkt_load_unit_if #(.ADDR_W(AW)) bus ();

  pkt_load_unit #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic [7:0]    pkt_mem [0:65535];
  exp_t          sb_q [$];
  logic [AW-1:0] rd_addr_q [$];
  int            rd_cyc_q [$];
  int            cyc = 0;
  int            acc_cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide buffer with one-cycle read latency; idle cycles return junk.
  always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? pkt_mem[bus.mem_addr] : 8'hEE;

  always @(negedge clk) begin
    if (bus.mem_rd_en) begin
      rd_addr_q.push_back(bus.mem_addr);
      rd_cyc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [1:0] sz, input logic be,
                      input logic [AW-1:0] len);
    int   n;
    exp_t x;
    bit   rdy;
    bit   ok;
    n = 1 << sz;
    x.data = 64'd0;
    x.err  = (int'(a) + n > int'(len));
    x.lat  = x.err ? 1 : n + 2;
    if (!x.err) begin
      for (int k = 0; k < n; k++) begin
        if (be) x.data = (x.data << 8) | 64'(pkt_mem[16'(int'(a) + k)]);
        else    x.data = x.data | (64'(pkt_mem[16'(int'(a) + k)]) << (8 * k));
      end
    end
    sb_q.push_back(x);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_size  = sz;
    bus.req_be    = be;
    bus.pkt_len   = len;
    ok = 1'b0;
    for (int w = 0; w < 50 && !ok; w++) begin
      rdy = bus.req_ready;
      tick();
      if (rdy) ok = 1'b1;
    end
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    // Scramble request inputs: the unit must only use what it sampled at accept.
    bus.req_addr = 16'($urandom);
    bus.req_size = ~sz;
    bus.req_be   = ~be;
    bus.pkt_len  = '0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout addr=%h got req_ready=0 required 1", a);
    end
  endtask

  task automatic wait_rsp(output logic [63:0] d, output logic er, output int lat);
    int w = 0;
    while (!bus.rsp_valid && w < 40) begin
      tick();
      w++;
    end
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout got rsp_valid=0 required 1");
    end
    d   = bus.rsp_data;
    er  = bus.rsp_err;
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic hs();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = 2'd0;
    bus.req_be    = 1'b0;
    bus.pkt_len   = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b rd=%b required 1 0 0",
               bus.req_ready, bus.rsp_valid, bus.mem_rd_en);
    end
    checks++;
    if (bus.mem_addr !== 16'h0 || bus.rsp_data !== 64'h0 || bus.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h err=%b required 0 0 0",
               bus.mem_addr, bus.rsp_data, bus.rsp_err);
    end
  endtask

  task automatic test_be2();
    logic [63:0] d; logic er; int lat; exp_t x;
    pkt_mem[11] = 8'h5C; pkt_mem[12] = 8'h08; pkt_mem[13] = 8'h00; pkt_mem[14] = 8'hC5;
    send(16'd12, 2'd1, 1'b1, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || d !== 64'h0800 || er !== 1'b0) begin
      errors++;
      $display("FAIL be2_data got %h err=%b required %h err=0", d, er, x.data);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL be2_latency got %0d required 4", lat);
    end
    checks++;
    if (rd_addr_q.size() != 2 || rd_addr_q[0] !== 16'd12 || rd_addr_q[1] !== 16'd13 ||
        rd_cyc_q[0] != acc_cyc || rd_cyc_q[1] != acc_cyc + 1) begin
      errors++;
      $display("FAIL be2_reads got %0d reads first=%h required 2 reads 000c,000d back to back",
               rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 16'hxxxx);
    end
    hs();
  endtask

  task automatic test_endian4();
    logic [63:0] d; logic er; int lat; exp_t x;
    pkt_mem[0] = 8'h11; pkt_mem[1] = 8'h22; pkt_mem[2] = 8'h33; pkt_mem[3] = 8'h44;
    pkt_mem[4] = 8'h99;
    for (int b = 0; b < 2; b++) begin
      send(16'd0, 2'd2, b[0], 16'd64);
      wait_rsp(d, er, lat);
      x = sb_q.pop_front();
      checks++;
      if (d !== x.data || er !== 1'b0 || lat !== 6) begin
        errors++;
        $display("FAIL endian4_be%0d got %h err=%b lat=%0d required %h err=0 lat=6",
                 b, d, er, lat, x.data);
      end
      hs();
    end
  endtask

  task automatic test_be8();
    logic [63:0] d; logic er; int lat; exp_t x;
    for (int k = 0; k < 8; k++) pkt_mem[8 + k] = 8'(k + 1);
    send(16'd8, 2'd3, 1'b1, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || d !== 64'h0102030405060708 || er !== 1'b0) begin
      errors++;
      $display("FAIL be8_data got %h err=%b required %h err=0", d, er, x.data);
    end
    checks++;
    if (lat !== 10 || rd_addr_q.size() != 8) begin
      errors++;
      $display("FAIL be8_timing got lat=%0d reads=%0d required lat=10 reads=8",
               lat, rd_addr_q.size());
    end
    hs();
  endtask

  task automatic test_last_byte();
    logic [63:0] d; logic er; int lat; exp_t x;
    pkt_mem[62] = 8'h77; pkt_mem[63] = 8'hAB; pkt_mem[64] = 8'h66;
    send(16'd63, 2'd0, 1'b1, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || d !== 64'hAB || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL last_byte got %h err=%b lat=%0d required %h err=0 lat=3",
               d, er, lat, x.data);
    end
    hs();
  endtask

  task automatic test_oob();
    logic [63:0] d; logic er; int lat; exp_t x;
    send(16'd63, 2'd1, 1'b1, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (er !== 1'b1 || d !== 64'h0 || lat !== x.lat || lat !== 1) begin
      errors++;
      $display("FAIL oob got err=%b data=%h lat=%0d required err=1 data=0 lat=1", er, d, lat);
    end
    checks++;
    if (rd_addr_q.size() != 0) begin
      errors++;
      $display("FAIL oob_no_read got %0d reads required 0", rd_addr_q.size());
    end
    hs();
    send(16'hFFFE, 2'd2, 1'b0, 16'hFFFF);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (er !== x.err || er !== 1'b1 || d !== 64'h0 || rd_addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap got err=%b data=%h reads=%0d required err=1 data=0 reads=0",
               er, d, rd_addr_q.size());
    end
    hs();
  endtask

  task automatic test_backpressure();
    logic [63:0] d; logic er; int lat; exp_t x;
    pkt_mem[40] = 8'hDE; pkt_mem[41] = 8'hAD; pkt_mem[42] = 8'hBE; pkt_mem[43] = 8'hEF;
    send(16'd40, 2'd2, 1'b1, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || er !== x.err) begin
      errors++;
      $display("FAIL bp_data got %h err=%b required %h err=%b", d, er, x.data, x.err);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== x.data || bus.rsp_err !== x.err ||
          bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b data=%h err=%b rdy=%b required 1 %h %b 0",
                 c, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready, x.data, x.err);
      end
    end
    hs();
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b required 1 0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d; logic er; int lat; exp_t x;
    for (int k = 0; k < 8; k++) pkt_mem[16 + k] = 8'hA0 + 8'(k);
    send(16'd16, 2'd3, 1'b1, 16'd64);
    x = sb_q.pop_back();
    tick();
    tick();
    checks++;
    if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 16'd18) begin
      errors++;
      $display("FAIL rstmid_issue3 got rd=%b addr=%h required 1 0012", bus.mem_rd_en, bus.mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.mem_rd_en !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after got rd=%b vld=%b rdy=%b required 0 0 1",
               bus.mem_rd_en, bus.rsp_valid, bus.req_ready);
    end
    pkt_mem[30] = 8'h3C; pkt_mem[31] = 8'hC3;
    send(16'd30, 2'd1, 1'b0, 16'd64);
    wait_rsp(d, er, lat);
    x = sb_q.pop_front();
    checks++;
    if (d !== x.data || d !== 64'hC33C || er !== 1'b0 || lat !== 4) begin
      errors++;
      $display("FAIL rstmid_next got %h err=%b lat=%0d required %h err=0 lat=4",
               d, er, lat, x.data);
    end
    hs();
  endtask

  task automatic test_back_to_back();
    logic [63:0] d; logic er; int lat; exp_t x;
    int prev_acc;
    int prev_lat;
    for (int a = 100; a < 208; a++) pkt_mem[a] = 8'($urandom);
    bus.rsp_ready = 1'b1;
    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 8; i++) begin
      send(16'($urandom_range(100, 199)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           16'd200);
      if (i > 0) begin
        checks++;
        if (acc_cyc - prev_acc != prev_lat + 1) begin
          errors++;
          $display("FAIL b2b_spacing%0d got %0d required %0d", i, acc_cyc - prev_acc,
                   prev_lat + 1);
        end
      end
      wait_rsp(d, er, lat);
      x = sb_q.pop_front();
      checks++;
      if (d !== x.data || er !== x.err || lat !== x.lat) begin
        errors++;
        $display("FAIL b2b_rsp%0d got %h err=%b lat=%0d required %h err=%b lat=%0d",
                 i, d, er, lat, x.data, x.err, x.lat);
      end
      prev_acc = acc_cyc;
      prev_lat = x.lat;
    end
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) pkt_mem[a] = 8'(a * 7 + 3);
    test_reset();
    test_be2();
    test_endian4();
    test_be8();
    test_last_byte();
    test_oob();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pkt_load_unit.md
# pkt_load_unit

Sequential packet-load engine for the eBPF core, used for `BPF_LD ABS/IND`-style accesses. It takes one load request at a time (1, 2, 4 or 8 bytes) and reads the bytes one per cycle from the byte-wide packet buffer. It assembles them into a 64-bit zero-extended result, converting from network (big-endian) order to host (little-endian) order on request. It is the load-side counterpart of the ALU byte-swap function: it turns wire-order bytes into host-order register values.

## Interface
- `ADDR_W`, default 16: packet buffer address width and packet length width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  1: load request present.
- `req_ready`  out  1: unit idle and able to accept a request.
- `req_addr`  in  ADDR_W: byte address of the first byte.
- `req_size`  in  2: access size. 00 = 1 B, 01 = 2 B, 10 = 4 B, 11 = 8 B.
- `req_be`  in  1: 1 = source is big-endian (swap to host order); 0 = source is little-endian (no swap).
- `pkt_len`  in  ADDR_W: number of valid bytes in the packet buffer.
- `mem_rd_en`  out  1: packet buffer read strobe.
- `mem_addr`  out  ADDR_W: packet buffer byte address.
- `mem_rdata`  in  8: read data. Valid exactly one cycle after `mem_rd_en`.
- `rsp_valid`  out  1: result available.
- `rsp_ready`  in  1: consumer accepts the result.
- `rsp_data`  out  64: assembled value, zero-extended.
- `rsp_err`  out  1: out-of-bounds access. `rsp_data` is 0 when this is set.

## Operation
- States: IDLE, ISSUE, DRAIN, RESP.
- `req_ready` = (state == IDLE), driven combinationally from the state register.
- Size decode: N = 1 << `req_size`.

IDLE:
- On `req_valid && req_ready`, latch `req_addr`, N, `req_be` and `pkt_len`.
- Bounds check uses ADDR_W+1-bit arithmetic: error if `req_addr` + N > `pkt_len`. Address wrap therefore always counts as an error.
- On error: `rsp_err`=1 and `rsp_data`=0 are registered, and the next state is RESP. No memory read is issued.
- Otherwise: clear the assembly register, reset the byte index i=0, and go to ISSUE.

ISSUE:
- Each cycle, drive `mem_rd_en`=1 and `mem_addr` = base + i, then increment i.
- After issuing byte N-1, go to DRAIN.

Data capture (ISSUE and DRAIN):
- A byte returned for index k is written into the assembly register at byte lane (N-1-k) when `req_be`=1, or at lane k when `req_be`=0.
- Lanes ≥ N stay 0.

DRAIN:
- Capture the last byte and go to RESP with `rsp_err`=0.

RESP:
- `rsp_valid`=1. `rsp_data` and `rsp_err` are held stable until `rsp_ready`=1.
- On the handshake, go to IDLE.
- A new request is never accepted in the same cycle as a response handshake.

Other rules:
- `pkt_len`, `req_*` and `req_be` are sampled only at acceptance. Later changes have no effect on the request in flight.
- `mem_rd_en` is 0 in every state other than ISSUE.

Reset:
- Any state goes to IDLE. The request in flight is abandoned and no response is produced.
- A `mem_rdata` beat arriving in the cycle after reset is ignored.
- Reset values: `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_rd_en`=0, `mem_addr`=0. `req_ready`=1 from the first cycle after reset deasserts.

## Timing
- Request accepted at edge T.
- `mem_rd_en` is high for cycles T+1 .. T+N, with addresses base .. base+N-1 in order.
- Data arrives in cycles T+2 .. T+N+1.
- `rsp_valid` rises at T+N+2. Accept-to-response latency is N+2 cycles: 3, 4, 6 and 10 for 1, 2, 4 and 8 B.
- Error path: `rsp_valid` at T+1.
- After a response handshake at edge R, `req_ready`=1 in cycle R+1. Minimum request spacing is therefore N+3 cycles when `rsp_ready` is held high.
- Throughput is one outstanding request. There is no pipelining across requests.

## Test plan
- **2 B big-endian:** `pkt_len`=64, addr 12, buffer[12..13] = 0x08, 0x00 → `rsp_data`=0x0000_0000_0000_0800, `rsp_err`=0. `mem_addr` is 12 then 13 on consecutive cycles; `rsp_valid` 4 cycles after acceptance.
- **4 B little-endian and big-endian:** addr 0, bytes 0x11, 0x22, 0x33, 0x44. With `req_be`=0 → 0x44332211. With `req_be`=1 → 0x11223344.
- **8 B big-endian:** addr 8, bytes 0x01..0x08 → 0x0102030405060708, latency 10 cycles. **1 B at last byte:** addr 63, `pkt_len`=64, byte 0xAB → 0xAB, no error.
- **Out of bounds:** addr 63, size 2 B, `pkt_len`=64 → `rsp_err`=1, `rsp_data`=0, `rsp_valid` 1 cycle after acceptance, `mem_rd_en` never asserted. **Wrap:** addr 0xFFFE, size 4 B, `pkt_len`=0xFFFF → `rsp_err`=1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → `rsp_valid`, `rsp_data` and `rsp_err` stay stable and `req_ready` stays 0. After the handshake, `req_ready`=1 on the next cycle.
- **Reset mid-read:** assert `rst` during the third ISSUE cycle of an 8 B load → the next cycle has `mem_rd_en`=0, `rsp_valid`=0 and `req_ready`=1 once reset deasserts. A following 2 B request returns the correct, uncorrupted value.
